if_stage_mo: RTL and testbench

Instruction-fetch stage with up to MAX_OUTSTANDING pipelined requests on the SRAM-like instruction port, and an IBUF_DEPTH-entry instruction buffer toward decode. Redirects (exception, ertn, taken branch) discard stale in-flight responses with a cancel counter, so no response is lost. It replaces the single-outstanding fetch stage between the instruction bus and the decode stage, and keeps the same flush sources and ADEF reporting.

---
 rtl/if_stage_mo.sv | 192 +++++++++++++++++++
 tb/tb_if_stage_mo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage_mo.sv
// Instruction fetch: up to MAX_OUTSTANDING pipelined SRAM requests feeding an IBUF_DEPTH buffer; head valid one cycle after data_ok.
// Backpressure: issue stalls on the outstanding limit or buffer credit; a request shown without addr_ok is held stable until accepted.
module if_stage_mo #(
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 4,
  parameter logic [31:0] RESET_PC        = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [31:0] eentry,
  input  logic [31:0] era,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_to_ds_pc,
  output logic [31:0] fs_to_ds_inst,
  output logic        fs_to_ds_excp,
  output logic [15:0] fs_to_ds_excp_num,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW = $clog2(IBUF_DEPTH);
  localparam int NW = $clog2(IBUF_DEPTH + 1);
  localparam logic [PW-1:0] PF_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] MAX_OUT = CW'(MAX_OUTSTANDING);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          held_q, held_d;
  logic          pend_vld_q, pend_vld_d;
  logic [31:0]   pend_pc_q, pend_pc_d;
  logic          halt_q, halt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [31:0]   pf_mem_q [MAX_OUTSTANDING];
  logic [31:0]   pf_mem_d [MAX_OUTSTANDING];
  logic [PW-1:0] pf_wp_q, pf_wp_d, pf_rp_q, pf_rp_d;
  logic [31:0]   ib_pc_q [IBUF_DEPTH];
  logic [31:0]   ib_pc_d [IBUF_DEPTH];
  logic [31:0]   ib_inst_q [IBUF_DEPTH];
  logic [31:0]   ib_inst_d [IBUF_DEPTH];
  logic          ib_excp_q [IBUF_DEPTH];
  logic          ib_excp_d [IBUF_DEPTH];
  logic [BW-1:0] ib_wp_q, ib_wp_d, ib_rp_q, ib_rp_d;
  logic [NW-1:0] ib_cnt_q, ib_cnt_d;

  logic        redir, can_issue, hs, dok, drop, adef_push, ib_push, ib_pop, has_head;
  logic [31:0] redir_pc;

  function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
    return (p == PF_LAST) ? '0 : p + 1'b1;
  endfunction

  assign redir    = excp_flush | ertn_flush | (br_taken & ds_allowin);
  assign redir_pc = excp_flush ? eentry : (ertn_flush ? era : br_target);

  assign can_issue = (out_q < MAX_OUT) && ((int'(out_q) + int'(ib_cnt_q)) < IBUF_DEPTH)
                     && (fetch_pc_q[1:0] == 2'b00) && !halt_q;
  assign inst_sram_req   = !reset && (held_q || can_issue);
  assign inst_sram_addr  = fetch_pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  assign hs   = inst_sram_req & inst_sram_addr_ok;
  assign dok  = inst_sram_data_ok & (out_q != '0);
  assign drop = dok & (disc_q != '0);
  // ADEF is reported only once every older response has drained, so it cannot overtake them.
  assign adef_push = !inst_sram_req && (fetch_pc_q[1:0] != 2'b00) && (out_q == '0) && (disc_q == '0)
                     && !halt_q && !redir && (ib_cnt_q < NW'(IBUF_DEPTH));
  assign ib_push = (dok & !drop) | adef_push;

  assign has_head          = (ib_cnt_q != '0);
  assign fs_to_ds_valid    = has_head & !redir;
  assign ib_pop            = fs_to_ds_valid & ds_allowin;
  assign fs_to_ds_pc       = has_head ? ib_pc_q[ib_rp_q] : 32'h0;
  assign fs_to_ds_inst     = has_head ? ib_inst_q[ib_rp_q] : 32'h0;
  assign fs_to_ds_excp     = has_head & ib_excp_q[ib_rp_q];
  assign fs_to_ds_excp_num = fs_to_ds_excp ? 16'h4000 : 16'h0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    halt_d     = halt_q;
    held_d     = inst_sram_req & !inst_sram_addr_ok;
    out_d      = out_q + CW'(hs) - CW'(dok);
    disc_d     = disc_q;
    pf_mem_d   = pf_mem_q;
    pf_wp_d    = pf_wp_q;
    pf_rp_d    = pf_rp_q;
    ib_pc_d    = ib_pc_q;
    ib_inst_d  = ib_inst_q;
    ib_excp_d  = ib_excp_q;
    ib_wp_d    = ib_wp_q;
    ib_rp_d    = ib_rp_q;
    ib_cnt_d   = ib_cnt_q;

    if (redir) begin
      // A request already on the bus must stay put, so its redirect target waits in pending.
      if (inst_sram_req && !inst_sram_addr_ok) begin
        pend_vld_d = 1'b1;
        pend_pc_d  = redir_pc;
      end else begin
        fetch_pc_d = redir_pc;
        pend_vld_d = 1'b0;
      end
      disc_d = out_d;
      halt_d = 1'b0;
    end else begin
      if (hs) begin
        fetch_pc_d = pend_vld_q ? pend_pc_q : fetch_pc_q + 32'd4;
        pend_vld_d = 1'b0;
      end
      disc_d = disc_q - CW'(drop) + CW'(hs & pend_vld_q);
      if (adef_push) halt_d = 1'b1;
    end

    if (hs) begin
      pf_mem_d[pf_wp_q] = fetch_pc_q;
      pf_wp_d           = pf_inc(pf_wp_q);
    end
    if (dok) pf_rp_d = pf_inc(pf_rp_q);

    if (redir) begin
      ib_wp_d  = '0;
      ib_rp_d  = '0;
      ib_cnt_d = '0;
    end else begin
      if (ib_push) begin
        ib_pc_d[ib_wp_q]   = dok ? pf_mem_q[pf_rp_q] : fetch_pc_q;
        ib_inst_d[ib_wp_q] = dok ? inst_sram_rdata : 32'h0;
        ib_excp_d[ib_wp_q] = !dok;
        ib_wp_d            = ib_wp_q + 1'b1;
      end
      if (ib_pop) ib_rp_d = ib_rp_q + 1'b1;
      ib_cnt_d = ib_cnt_q + NW'(ib_push) - NW'(ib_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      held_q     <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= 32'h0;
      halt_q     <= 1'b0;
      out_q      <= '0;
      disc_q     <= '0;
      pf_wp_q    <= '0;
      pf_rp_q    <= '0;
      ib_wp_q    <= '0;
      ib_rp_q    <= '0;
      ib_cnt_q   <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) pf_mem_q[i] <= 32'h0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        ib_pc_q[i]   <= 32'h0;
        ib_inst_q[i] <= 32'h0;
        ib_excp_q[i] <= 1'b0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      held_q     <= held_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      halt_q     <= halt_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      pf_wp_q    <= pf_wp_d;
      pf_rp_q    <= pf_rp_d;
      ib_wp_q    <= ib_wp_d;
      ib_rp_q    <= ib_rp_d;
      ib_cnt_q   <= ib_cnt_d;
      pf_mem_q   <= pf_mem_d;
      ib_pc_q    <= ib_pc_d;
      ib_inst_q  <= ib_inst_d;
      ib_excp_q  <= ib_excp_d;
    end
  end
endmodule

// File: tb/tb_if_stage_mo.sv
// Bench for if_stage_mo: directed redirect/ADEF/backpressure scenarios with a latency-programmable SRAM model.
// Expected decode-side entries are queued by the stimulus and popped by an independent monitor.
module tb_if_stage_mo;
  logic        clk = 1'b0;
  logic        reset, ds_allowin, excp_flush, ertn_flush, br_taken;
  logic [31:0] eentry, era, br_target;
  logic        fs_to_ds_valid, fs_to_ds_excp;
  logic [31:0] fs_to_ds_pc, fs_to_ds_inst;
  logic [15:0] fs_to_ds_excp_num;
  logic        inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic excp; int cyc; } exp_t;
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  exp_t sb[$];
  rsp_t mq[$];
  rsp_t mem_r;
  exp_t mon_e;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int lat = 1;
  int ao_hold = 0;

  if_stage_mo dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .eentry(eentry), .era(era),
    .br_taken(br_taken), .br_target(br_target),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc), .fs_to_ds_inst(fs_to_ds_inst),
    .fs_to_ds_excp(fs_to_ds_excp), .fs_to_ds_excp_num(fs_to_ds_excp_num),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // Cycle 0 is the first cycle after reset release.
  always @(posedge clk) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5a5a_a5a5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst, input logic excp, input int c);
    exp_t e;
    e.pc = pc; e.inst = inst; e.excp = excp; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic push_ok(input logic [31:0] pc, input int c);
    push_exp(pc, mem_word(pc), 1'b0, c);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; ds_allowin = 1'b1; excp_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
    eentry = 32'h0; era = 32'h0; br_target = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() > 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL %s_drain: %0d entries still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // SRAM model: addr_ok held low until cycle ao_hold, data returned lat cycles after the handshake.
  initial begin
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        mq.delete();
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
      end else begin
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata   = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          mem_r = mq.pop_front();
          inst_sram_data_ok = 1'b1;
          inst_sram_rdata   = mem_word(mem_r.addr);
        end
        inst_sram_addr_ok = (cyc >= ao_hold);
        if (inst_sram_req && inst_sram_addr_ok) begin
          mem_r.addr = inst_sram_addr;
          mem_r.due  = cyc + lat;
          mq.push_back(mem_r);
        end
      end
    end
  end

  // Monitor: every decode-side transfer is compared against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!reset && fs_to_ds_valid && ds_allowin && sb.size() > 0) begin
        mon_e = sb.pop_front();
        check("out_pc", fs_to_ds_pc, mon_e.pc);
        check("out_inst", fs_to_ds_inst, mon_e.inst);
        check("out_excp", {15'd0, fs_to_ds_excp, fs_to_ds_excp_num},
              {15'd0, mon_e.excp, (mon_e.excp ? 16'h4000 : 16'h0)});
        check("out_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    reset = 1'b1; ds_allowin = 1'b1; excp_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
    eentry = 32'h0; era = 32'h0; br_target = 32'h0;
    @(negedge clk);
    #3;
    check("rst_req", {31'd0, inst_sram_req}, 32'd0);
    check("rst_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    check("rst_pc", fs_to_ds_pc, 32'h0);
    check("rst_inst", fs_to_ds_inst, 32'h0);
    check("rst_excp", {15'd0, fs_to_ds_excp, fs_to_ds_excp_num}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Zero-wait memory: one instruction per cycle from cycle 2
    push_ok(32'h1c000000, 2); push_ok(32'h1c000004, 3);
    push_ok(32'h1c000008, 4); push_ok(32'h1c00000c, 5);
    #3;
    check("first_req", {31'd0, inst_sram_req}, 32'd1);
    check("first_addr", inst_sram_addr, 32'h1c000000);
    check("sram_const", {inst_sram_wr, inst_sram_size, inst_sram_wstrb, 25'd0}, {1'b0, 2'b10, 4'h0, 25'd0});
    check("sram_wdata", inst_sram_wdata, 32'h0);
    drain("zero_wait");

    // Three-cycle latency: stall after two handshakes, order preserved
    lat = 3;
    do_reset();
    push_ok(32'h1c000000, 4); push_ok(32'h1c000004, 5);
    push_ok(32'h1c000008, 8); push_ok(32'h1c00000c, 9);
    wait_cyc(2); #3;
    check("lat3_stall_req", {31'd0, inst_sram_req}, 32'd0);
    wait_cyc(4); #3;
    check("lat3_resume_req", {31'd0, inst_sram_req}, 32'd1);
    check("lat3_resume_addr", inst_sram_addr, 32'h1c000008);
    drain("lat3");

    // Branch with two requests in flight: both responses dropped
    do_reset();
    push_ok(32'h1c000100, 8); push_ok(32'h1c000104, 9);
    wait_cyc(2);
    br_taken = 1'b1; br_target = 32'h1c000100;
    wait_cyc(3);
    br_taken = 1'b0;
    wait_cyc(4); #3;
    check("br_inflight_req", {31'd0, inst_sram_req}, 32'd1);
    check("br_inflight_addr", inst_sram_addr, 32'h1c000100);
    drain("br_inflight");

    // Branch while buffer holds an entry: valid suppressed, stale data dropped
    lat = 1;
    do_reset();
    push_ok(32'h1c000000, 2); push_ok(32'h1c000200, 6); push_ok(32'h1c000204, 7);
    wait_cyc(3);
    br_taken = 1'b1; br_target = 32'h1c000200;
    #3;
    check("br_valid_low", {31'd0, fs_to_ds_valid}, 32'd0);
    wait_cyc(4);
    br_taken = 1'b0;
    #3;
    check("br_next_addr", inst_sram_addr, 32'h1c000200);
    drain("br_buffer");

    // Held request plus simultaneous exception and branch: eentry wins, held response dropped
    ao_hold = 2;
    do_reset();
    push_ok(32'h1c008000, 5); push_ok(32'h1c008004, 6);
    wait_cyc(1);
    excp_flush = 1'b1; eentry = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000300;
    #3;
    check("held_req_c1", {31'd0, inst_sram_req}, 32'd1);
    check("held_addr_c1", inst_sram_addr, 32'h1c000000);
    wait_cyc(2);
    excp_flush = 1'b0; br_taken = 1'b0;
    #3;
    check("held_addr_c2", {inst_sram_addr[31:1], inst_sram_req}, {31'h0e000000, 1'b1});
    wait_cyc(3); #3;
    check("held_next_addr", inst_sram_addr, 32'h1c008000);
    drain("held");
    ao_hold = 0;

    // Misaligned ertn target: one ADEF entry, then idle until a redirect
    do_reset();
    ertn_flush = 1'b1; era = 32'h1c000102;
    push_exp(32'h1c000102, 32'h0, 1'b1, 3);
    push_ok(32'h1c000400, 11);
    wait_cyc(1);
    ertn_flush = 1'b0;
    for (int c = 4; c < 8; c++) begin
      wait_cyc(c); #3;
      check("adef_idle_req", {31'd0, inst_sram_req}, 32'd0);
    end
    check("adef_idle_valid", {31'd0, fs_to_ds_valid}, 32'd0);
    wait_cyc(8);
    br_taken = 1'b1; br_target = 32'h1c000400;
    wait_cyc(9);
    br_taken = 1'b0;
    #3;
    check("adef_resume_req", {31'd0, inst_sram_req}, 32'd1);
    check("adef_resume_addr", inst_sram_addr, 32'h1c000400);
    drain("adef");

    // Decode stalled 10 cycles: buffer fills to 4, no overflow, in-order drain
    do_reset();
    ds_allowin = 1'b0;
    push_ok(32'h1c000000, 10); push_ok(32'h1c000004, 11); push_ok(32'h1c000008, 12);
    push_ok(32'h1c00000c, 13); push_ok(32'h1c000010, 14);
    wait_cyc(6); #3;
    check("full_req", {31'd0, inst_sram_req}, 32'd0);
    check("full_valid", {31'd0, fs_to_ds_valid}, 32'd1);
    wait_cyc(9); #3;
    check("full_req_late", {31'd0, inst_sram_req}, 32'd0);
    wait_cyc(10);
    ds_allowin = 1'b1;
    drain("full");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
